alu4_rr_sched: RTL and testbench

Round-robin scheduler that shares one alu4 instance between NREQ requesters. Each requester presents a func/a/b operation with a valid/ready handshake. The scheduler grants one requester, runs the op through alu4 and returns a registered result tagged with the requester id. A downstream valid/ready handshake gives backpressure. It replaces button-stepped func selection when several masters need the ALU.

---
 rtl/alu4_sched_pkg.sv | 18 +
 rtl/alu4.sv | 26 ++
 rtl/alu4_rr_pick.sv | 29 ++
 rtl/alu4_rr_sched.sv | 110 +++++++++++
 tb/tb_alu4_rr_sched.sv | 396 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu4_sched_pkg.sv
// Shared constants and op bundle for the alu4 round-robin scheduler.
// Optional statistics counter is enabled by ALU4_RR_SCHED_STATS_EN.
package alu4_sched_pkg;

  localparam int FUNC_W = 3;
  localparam int DATA_W = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  typedef struct packed {
    logic [FUNC_W-1:0] func;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } op_t;

endpackage

// File: rtl/alu4.sv
// 4-bit ALU: add, sub, and, or, xor, not a, shl a, shr a.
// Results wrap/truncate to 4 bits.
module alu4
  import alu4_sched_pkg::*;
(
  input  logic [FUNC_W-1:0] func,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    y = '0;
    unique case (func)
      3'b000: y = a + b;
      3'b001: y = a - b;
      3'b010: y = a & b;
      3'b011: y = a | b;
      3'b100: y = a ^ b;
      3'b101: y = ~a;
      3'b110: y = {a[DATA_W-2:0], 1'b0};
      3'b111: y = {1'b0, a[DATA_W-1:1]};
    endcase
  end

endmodule

// File: rtl/alu4_rr_pick.sv
// Combinational round-robin picker: first valid at or after rr_ptr,
// wrapping modulo NREQ.
module alu4_rr_pick #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            any_valid
);

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!any_valid && req_valid[idx]) begin
        any_valid   = 1'b1;
        grant[idx]  = 1'b1;
        grant_idx   = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/alu4_rr_sched.sv
// Round-robin scheduler sharing one alu4 between NREQ requesters.
// Define ALU4_RR_SCHED_STATS_EN to add the saturating op_count output.
module alu4_rr_sched
  import alu4_sched_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [FUNC_W*NREQ-1:0]   req_func,
  input  logic [DATA_W*NREQ-1:0]   req_a,
  input  logic [DATA_W*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]          req_ready,
  output logic                     res_valid,
  output logic [DATA_W-1:0]        res_y,
  output logic [FUNC_W-1:0]        res_func,
  output logic [IDW-1:0]           res_id,
  input  logic                     res_ready
`ifdef ALU4_RR_SCHED_STATS_EN
  ,
  output logic [7:0]               op_count
`endif
);

  logic [1:0]        state;
  logic [IDW-1:0]    rr_ptr;
  logic [IDW-1:0]    op_id;
  op_t               op;
  logic [NREQ-1:0]   pick_oh;
  logic [IDW-1:0]    pick_idx;
  logic              pick_any;
  logic [IDW-1:0]    ptr_nxt;
  logic [DATA_W-1:0] alu_y;

  alu4_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (pick_oh),
    .grant_idx (pick_idx),
    .any_valid (pick_any)
  );

  alu4 u_alu (
    .func (op.func),
    .a    (op.a),
    .b    (op.b),
    .y    (alu_y)
  );

  assign ptr_nxt = (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;

  // Grant only in IDLE, and never while reset is asserted.
  assign req_ready = (rst_n && state == S_IDLE) ? pick_oh : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      op_id     <= '0;
      op        <= '0;
      res_valid <= 1'b0;
      res_y     <= '0;
      res_func  <= '0;
      res_id    <= '0;
    end else begin
      unique case (1'b1)
        (state == S_IDLE): begin
          if (pick_any) begin
            op.func <= req_func[FUNC_W*pick_idx +: FUNC_W];
            op.a    <= req_a[DATA_W*pick_idx +: DATA_W];
            op.b    <= req_b[DATA_W*pick_idx +: DATA_W];
            op_id   <= pick_idx;
            rr_ptr  <= ptr_nxt;
            state   <= S_EXEC;
          end
        end
        (state == S_EXEC): begin
          res_y     <= alu_y;
          res_func  <= op.func;
          res_id    <= op_id;
          res_valid <= 1'b1;
          state     <= S_HOLD;
        end
        (state == S_HOLD): begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ALU4_RR_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (state == S_HOLD && res_ready && op_count != 8'hFF) begin
      op_count <= op_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu4_rr_sched.sv
// Scoreboard bench for alu4_rr_sched (NREQ=2).
// Exercises op_count saturation when ALU4_RR_SCHED_STATS_EN is defined.
module tb_alu4_rr_sched;
  import alu4_sched_pkg::*;

  localparam int NREQ = 2;
  localparam int IDW  = 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [3*NREQ-1:0] req_func = '0;
  logic [4*NREQ-1:0] req_a = '0;
  logic [4*NREQ-1:0] req_b = '0;
  logic [NREQ-1:0]   req_ready;
  logic              res_valid;
  logic [3:0]        res_y;
  logic [2:0]        res_func;
  logic [IDW-1:0]    res_id;
  logic              res_ready = 1'b0;
`ifdef ALU4_RR_SCHED_STATS_EN
  logic [7:0]        op_count;
`endif

  typedef struct packed {
    logic [3:0]     y;
    logic [2:0]     f;
    logic [IDW-1:0] id;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   errors  = 0;
  int   m_ptr   = 0;

  alu4_rr_sched #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_func  (req_func),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_y     (res_y),
    .res_func  (res_func),
    .res_id    (res_id),
    .res_ready (res_ready)
`ifdef ALU4_RR_SCHED_STATS_EN
    ,
    .op_count  (op_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] alu_ref(logic [2:0] f, logic [3:0] a,
                                         logic [3:0] b);
    case (f)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return a ^ b;
      3'b101:  return ~a;
      3'b110:  return {a[2:0], 1'b0};
      default: return {1'b0, a[3:1]};
    endcase
  endfunction

  function automatic logic [NREQ-1:0] pick_ref(logic [NREQ-1:0] v, int p);
    logic [NREQ-1:0] oh;
    oh = '0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (p + k) % NREQ;
      if (oh == '0 && v[idx]) oh[idx] = 1'b1;
    end
    return oh;
  endfunction

  function automatic int idx_of(logic [NREQ-1:0] oh);
    for (int k = 0; k < NREQ; k++) if (oh[k]) return k;
    return -1;
  endfunction

  function automatic exp_t exp_of(int g);
    exp_t e;
    e.f  = req_func[3*g +: 3];
    e.y  = alu_ref(e.f, req_a[4*g +: 4], req_b[4*g +: 4]);
    e.id = IDW'(g);
    return e;
  endfunction

  task automatic set_req(int i, logic v, logic [2:0] f, logic [3:0] a,
                         logic [3:0] b);
    req_valid[i]     = v;
    req_func[3*i +: 3] = f;
    req_a[4*i +: 4]  = a;
    req_b[4*i +: 4]  = b;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (req_ready !== '0) begin
      errors++; $display("FAIL reset_ready: got %b want 0", req_ready);
    end
    vectors++;
    if ({res_valid, res_y, res_func, res_id} !== '0) begin
      errors++;
      $display("FAIL reset_outs: got v=%b y=%h f=%h id=%h want all 0",
               res_valid, res_y, res_func, res_id);
    end
    rst_n = 1'b1;
    m_ptr = 0;
  endtask

  // One op from a lone requester, data scrambled right after grant.
  task automatic test_single(int id, logic [2:0] f, logic [3:0] a,
                             logic [3:0] b, logic [3:0] y_exp);
    exp_t e, got;
    int   lat;
    @(posedge clk); #1;
    res_ready = 1'b1;
    req_valid = '0;
    set_req(id, 1'b1, f, a, b);
    #1;
    vectors++;
    if (req_ready !== NREQ'(1 << id)) begin
      errors++;
      $display("FAIL single_grant: got %b want %b", req_ready,
               NREQ'(1 << id));
    end
    e.y = y_exp; e.f = f; e.id = IDW'(id);
    sb.push_back(e);
    m_ptr = (id + 1) % NREQ;
    @(posedge clk); #1;
    set_req(id, 1'b0, ~f, ~a, ~b);
    lat = 1;
    while (!res_valid && lat < 10) begin
      @(posedge clk); #1; lat++;
    end
    vectors++;
    if (lat !== 2) begin
      errors++; $display("FAIL single_latency: got %0d want 2", lat);
    end
    got = {res_y, res_func, res_id};
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    vectors++;
    if (got !== e) begin
      errors++;
      $display("FAIL single_result: got y=%h f=%h id=%h want y=%h f=%h id=%h",
               res_y, res_func, res_id, e.y, e.f, e.id);
    end
    @(posedge clk); #1;
    vectors++;
    if (res_valid !== 1'b0) begin
      errors++; $display("FAIL single_release: res_valid got %b want 0",
                         res_valid);
    end
  endtask

  task automatic test_rotation();
    int st = 0, nres = 0, last = -1, gpend = -1, g;
    logic [NREQ-1:0] exp_rdy;
    exp_t e, got;
    @(posedge clk); #2;
    res_ready = 1'b1;
    for (int i = 0; i < NREQ; i++)
      set_req(i, 1'b1, 3'($urandom_range(7)), 4'($urandom_range(15)),
              4'($urandom_range(15)));
    #1;
    for (int c = 0; c < 40 && nres < 8; c++) begin
      exp_rdy = (st == 0) ? pick_ref(req_valid, m_ptr) : '0;
      vectors++;
      if (req_ready !== exp_rdy) begin
        errors++; $display("FAIL rot_grant c%0d: got %b want %b", c,
                           req_ready, exp_rdy);
      end
      vectors++;
      if (res_valid !== (st == 2)) begin
        errors++; $display("FAIL rot_valid c%0d: got %b want %b", c,
                           res_valid, st == 2);
      end
      if (st == 0) begin
        g = idx_of(exp_rdy);
        sb.push_back(exp_of(g));
        m_ptr = (g + 1) % NREQ;
        gpend = g;
        st = 1;
      end else if (st == 1) begin
        st = 2;
      end else begin
        got = {res_y, res_func, res_id};
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        vectors++;
        if (got !== e) begin
          errors++;
          $display("FAIL rot_result %0d: got y=%h f=%h id=%h want y=%h f=%h id=%h",
                   nres, res_y, res_func, res_id, e.y, e.f, e.id);
        end
        if (last >= 0) begin
          vectors++;
          if (c - last !== 3) begin
            errors++; $display("FAIL rot_interval: got %0d want 3", c - last);
          end
        end
        last = c;
        nres++;
        st = 0;
      end
      @(posedge clk); #1;
      if (gpend >= 0) begin
        set_req(gpend, 1'b1, 3'($urandom_range(7)), 4'($urandom_range(15)),
                4'($urandom_range(15)));
        gpend = -1;
      end
      #1;
    end
    vectors++;
    if (nres !== 8) begin
      errors++; $display("FAIL rot_timeout: got %0d results want 8", nres);
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    logic [NREQ-1:0] exp_rdy;
    exp_t e, got;
    int   g, lat;
    @(posedge clk); #1;
    res_ready = 1'b0;
    set_req(0, 1'b1, 3'b001, 4'd2, 4'd7);
    set_req(1, 1'b1, 3'b100, 4'd12, 4'd5);
    #1;
    exp_rdy = pick_ref(req_valid, m_ptr);
    vectors++;
    if (req_ready !== exp_rdy) begin
      errors++; $display("FAIL bp_grant: got %b want %b", req_ready, exp_rdy);
    end
    g = idx_of(exp_rdy);
    e = exp_of(g);
    sb.push_back(e);
    m_ptr = (g + 1) % NREQ;
    repeat (2) @(posedge clk);
    #1;
    got = {res_y, res_func, res_id};
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    vectors++;
    if (!res_valid || got !== e) begin
      errors++;
      $display("FAIL bp_result: got v=%b y=%h id=%h want v=1 y=%h id=%h",
               res_valid, res_y, res_id, e.y, e.id);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      vectors++;
      if (!res_valid || {res_y, res_func, res_id} !== e ||
          req_ready !== '0) begin
        errors++;
        $display("FAIL bp_hold c%0d: got v=%b y=%h id=%h rdy=%b want v=1 y=%h id=%h rdy=0",
                 c, res_valid, res_y, res_id, req_ready, e.y, e.id);
      end
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    exp_rdy = pick_ref(req_valid, m_ptr);
    vectors++;
    if (res_valid !== 1'b0 || req_ready !== exp_rdy) begin
      errors++;
      $display("FAIL bp_release: got v=%b rdy=%b want v=0 rdy=%b",
               res_valid, req_ready, exp_rdy);
    end
    g = idx_of(exp_rdy);
    sb.push_back(exp_of(g));
    m_ptr = (g + 1) % NREQ;
    @(posedge clk); #1;
    req_valid = '0;
    lat = 0;
    while (!res_valid && lat < 10) begin
      @(posedge clk); #1; lat++;
    end
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    vectors++;
    if (!res_valid || {res_y, res_func, res_id} !== e) begin
      errors++;
      $display("FAIL bp_next: got v=%b y=%h id=%h want v=1 y=%h id=%h",
               res_valid, res_y, res_id, e.y, e.id);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   lat;
    @(posedge clk); #1;
    res_ready = 1'b1;
    req_valid = '0;
    set_req(0, 1'b1, 3'b000, 4'd6, 4'd6);
    #1;
    vectors++;
    if (req_ready !== 2'b01) begin
      errors++; $display("FAIL rm_grant: got %b want 01", req_ready);
    end
    @(posedge clk); #1;
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (req_ready !== '0) begin
      errors++; $display("FAIL rm_ready_in_reset: got %b want 0", req_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_ptr = 0;
    vectors++;
    if (res_valid !== 1'b0 || res_y !== 4'd0 || res_id !== '0) begin
      errors++;
      $display("FAIL rm_outs: got v=%b y=%h id=%h want 0", res_valid, res_y,
               res_id);
    end
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      vectors++;
      if (res_valid !== 1'b0) begin
        errors++; $display("FAIL rm_dropped c%0d: res_valid got 1 want 0", c);
      end
    end
    set_req(0, 1'b1, 3'b010, 4'hC, 4'hA);
    set_req(1, 1'b1, 3'b011, 4'h1, 4'h4);
    #1;
    vectors++;
    if (req_ready !== 2'b01) begin
      errors++; $display("FAIL rm_ptr: got %b want 01", req_ready);
    end
    sb.push_back(exp_of(0));
    m_ptr = 1;
    @(posedge clk); #1;
    req_valid = '0;
    lat = 0;
    while (!res_valid && lat < 10) begin
      @(posedge clk); #1; lat++;
    end
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    vectors++;
    if (!res_valid || {res_y, res_func, res_id} !== e) begin
      errors++;
      $display("FAIL rm_after: got v=%b y=%h id=%h want v=1 y=%h id=%h",
               res_valid, res_y, res_id, e.y, e.id);
    end
  endtask

`ifdef ALU4_RR_SCHED_STATS_EN
  task automatic test_stats();
    @(posedge clk); #1;
    res_ready = 1'b1;
    set_req(0, 1'b1, 3'b000, 4'd1, 4'd1);
    repeat (950) @(posedge clk);
    #1;
    req_valid = '0;
    repeat (4) @(posedge clk);
    #1;
    vectors++;
    if (op_count !== 8'd255) begin
      errors++; $display("FAIL stats_sat: got %0d want 255", op_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single(0, 3'b000, 4'd3, 4'd5, 4'd8);
    test_single(0, 3'b000, 4'd9, 4'd9, 4'd2);
    test_single(1, 3'b001, 4'd2, 4'd5, alu_ref(3'b001, 4'd2, 4'd5));
    test_single(0, 3'b010, 4'hE, 4'h7, alu_ref(3'b010, 4'hE, 4'h7));
    test_single(1, 3'b011, 4'h8, 4'h3, alu_ref(3'b011, 4'h8, 4'h3));
    test_single(0, 3'b100, 4'hF, 4'hA, alu_ref(3'b100, 4'hF, 4'hA));
    test_single(1, 3'b101, 4'h5, 4'h0, alu_ref(3'b101, 4'h5, 4'h0));
    test_single(0, 3'b110, 4'h9, 4'h0, alu_ref(3'b110, 4'h9, 4'h0));
    test_single(1, 3'b111, 4'hB, 4'h0, alu_ref(3'b111, 4'hB, 4'h0));
    test_rotation();
    test_backpressure();
    test_reset_mid();
`ifdef ALU4_RR_SCHED_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
